// File: rtl/gray_debounce_decoder.sv
// Synchronises and debounces an asynchronous Gray-coded switch bank, then commits the
// settled word and its binary equivalent with a one-cycle strobe.
module gray_debounce_decoder #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned DB_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_stable,
    output logic             bin_valid,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        COMMIT = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sync1_q, sync_q;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] gray_stable_q, gray_stable_d;
    logic [WIDTH-1:0] bin_out_q, bin_out_d;
    logic             bin_valid_q, bin_valid_d;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Two-flop synchroniser; only sync_q is seen by the qualifier
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync_q  <= '0;
        end else begin
            sync1_q <= gray_in;
            sync_q  <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cand_q        <= '0;
            cnt_q         <= '0;
            gray_stable_q <= '0;
            bin_out_q     <= '0;
            bin_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cand_q        <= cand_d;
            cnt_q         <= cnt_d;
            gray_stable_q <= gray_stable_d;
            bin_out_q     <= bin_out_d;
            bin_valid_q   <= bin_valid_d;
        end
    end

    // Qualification: any change of the candidate restarts the count; return to the
    // committed value abandons the candidate without a strobe
    always_comb begin
        state_d       = state_q;
        cand_d        = cand_q;
        cnt_d         = cnt_q;
        gray_stable_d = gray_stable_q;
        bin_out_d     = bin_out_q;
        bin_valid_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync_q != gray_stable_q) begin
                    cand_d  = sync_q;
                    cnt_d   = '0;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (sync_q == gray_stable_q) begin
                    state_d = IDLE;
                end else if (sync_q != cand_q) begin
                    cand_d = sync_q;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = COMMIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            COMMIT: begin
                gray_stable_d = cand_q;
                bin_out_d     = gray2bin(cand_q);
                bin_valid_d   = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bin_out     = bin_out_q;
    assign gray_stable = gray_stable_q;
    assign bin_valid   = bin_valid_q;
    assign busy        = (state_q == COUNT) || (state_q == COMMIT);

endmodule
